ov7670_sccb_config: RTL and testbench
=====================================

Name: ov7670_sccb_config

Overview:
- SCCB (I2C-like) write-only master that programs the OV7670 register set after power-up, before capture begins.
- Sits upstream of the camera: its output configures the sensor, and that configuration sets the frame the capture/downsampler stage receives (RGB565, 160x120, PCLK rate).
- Steps through a fixed register table in a ROM sub-module and issues one 3-phase write per entry.
- Reports busy/done to the top level; done can gate the capture path.

Parameters:
- CLK_FREQ_HZ, 25000000, frequency of clk in Hz.
- SCCB_FREQ_HZ, 100000, SIOC frequency in Hz. Quarter-period count Q = CLK_FREQ_HZ/(4*SCCB_FREQ_HZ), which is 62 at the defaults.
- DEV_ADDR, 8'h42, SCCB write ID of the camera.
- DELAY_MS, 10, wait length in ms when the table's delay marker is reached.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins table programming.
- sioc  out  1  SCCB clock.
- siod_out  out  1  SCCB data value to drive.
- siod_oe  out  1  1 = drive siod_out onto SIOD; 0 = release the line (pulled up).
- busy  out  1  high while the table is being programmed.
- done  out  1  high after the end marker; held until the next accepted start.
- reg_idx  out  6  index of the current table entry (debug).

Behaviour:
- Reset state (next edge after rst=1), regardless of the current state:
  - sioc=1, siod_out=1, siod_oe=0, busy=0, done=0, reg_idx=0.
  - FSM goes to IDLE; quarter counter, bit counter and delay counter cleared.
  - A transaction in flight is abandoned with the lines released, not stopped cleanly.
- Timebase: a quarter counter counts 0..Q-1 and emits a tick at Q-1. One SCCB bit = 4 ticks.
- Quarter-phase waveform for each bit:
  - q0: sioc=0.
  - q1: sioc=0, new SIOD value applied.
  - q2, q3: sioc=1.
- start handling: accepted only in IDLE or DONE. It sets busy=1, done=0, reg_idx=0 and moves to FETCH. Pulses while busy are ignored.
- FETCH: read the 16-bit entry {reg, val} at reg_idx; the ROM is combinational.
  - 16'hFFFF (end marker) -> DONE: busy=0, done=1.
  - 16'hFFF0 (delay marker) -> WAIT for DELAY_MS*CLK_FREQ_HZ/1000 cycles, then reg_idx+1 and back to FETCH.
  - Any other entry -> START.
- START: sioc=1 and siod=1 for one quarter, then siod=0 for one quarter (SIOD falls while SIOC is high). Then go to BITS.
- BITS: three phases of 9 bits each, in the order DEV_ADDR, reg, val.
  - Each phase sends 8 bits MSB first with siod_oe=1.
  - The 9th bit is don't-care: siod_oe=0 for all four quarters. ACK is not sampled.
  - Bit counter runs 0..26.
- STOP: one quarter sioc=0/siod=0, one quarter sioc=1/siod=0, one quarter sioc=1/siod=1. Then go to GAP.
- GAP: 4 quarters idle with sioc=1, siod=1, siod_oe=1. Then reg_idx+1 and FETCH.
- Counter widths: the delay counter is wide enough for DELAY_MS*CLK_FREQ_HZ/1000 (≥18 bits at the defaults). The table holds at most 64 entries.
- If reg_idx wraps to 0 without reaching an end marker, that is treated as done.

Optional Feature:
- Macro SCCB_TESTPAT_EN.
- Defined: the ROM inserts 0x70=0xBA and 0x71=0xB5 before the end marker, enabling the camera's 8-bar colour test pattern for display-path bring-up.
- Undefined: those two entries are absent and the table ends immediately after the normal configuration.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, FETCH, START, BITS, STOP, GAP, WAIT, DONE.
  - Marker constants CFG_END=16'hFFFF and CFG_DELAY=16'hFFF0.
  - OV7670 register address constants: COM7=0x12, COM15=0x40, COM3=0x0C, COM14=0x3E, CLKRC=0x11, RGB444=0x8C.
- Sub-module ov7670_cfg_rom: 6-bit index in, 16-bit entry out, combinational. Base table order:
  - 0x12=0x80 (soft reset)
  - delay marker
  - 0x12=0x14 (RGB)
  - 0x40=0xD0 (RGB565)
  - 0x8C=0x00
  - 0x11=0x01
  - 0x0C=0x04
  - 0x3E=0x1A (QQVGA scaling)
  - end marker

Test Plan:
- Reset: rst held 3 cycles with start=1 -> sioc=1, siod_oe=0, busy=0, done=0, reg_idx=0. The start is not accepted.
- First transaction (Q=62): start pulse -> SIOD falls while SIOC=1, then 27 bits of 248 cycles each.
  - Bus model decodes 0x42, 0x12, 0x80.
  - siod_oe=0 on bits 8, 17 and 26.
- Delay marker: after the first STOP+GAP, reg_idx=1 -> no SIOC edges for exactly 250000 cycles, then a transaction decoding 0x42, 0x12, 0x14.
- Full table: run to completion -> bus model logs exactly 7 writes in ROM order. Then busy=0, done=1, sioc=1, SIOD high.
  - With SCCB_TESTPAT_EN: 9 writes, the last two 0x70=0xBA and 0x71=0xB5.
- Start while busy: pulse start during the third write -> write sequence is unchanged and reg_idx is not reset.
- Reset mid-byte: assert rst during phase 2 bit 3 -> next edge sioc=1, siod_oe=0, busy=0. A following start restarts from reg_idx=0 with a clean START condition.

Source files
------------

// File: rtl/ov7670_sccb_config_pkg.sv
// Shared types and constants for the OV7670 SCCB register programmer.
package ov7670_sccb_config_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    BITS,
    STOP,
    GAP,
    WAIT,
    DONE
  } sccb_state_t;

  localparam logic [15:0] CFG_END   = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY = 16'hFFF0;

  localparam logic [7:0] COM7   = 8'h12;
  localparam logic [7:0] COM15  = 8'h40;
  localparam logic [7:0] COM3   = 8'h0C;
  localparam logic [7:0] COM14  = 8'h3E;
  localparam logic [7:0] CLKRC  = 8'h11;
  localparam logic [7:0] RGB444 = 8'h8C;

  function automatic logic [15:0] cfg_entry(input logic [7:0] addr, input logic [7:0] val);
    return {addr, val};
  endfunction

endpackage

// File: rtl/ov7670_cfg_rom.sv
// Combinational OV7670 register table, one {reg, val} entry per index.
// SCCB_TESTPAT_EN appends the colour-bar test pattern writes before the end marker.
module ov7670_cfg_rom
  import ov7670_sccb_config_pkg::*;
(
  input  logic [5:0]  idx,
  output logic [15:0] entry
);

  always_comb begin
    entry = CFG_END;
    case (idx)
      6'd0: entry = cfg_entry(COM7, 8'h80);
      6'd1: entry = CFG_DELAY;
      6'd2: entry = cfg_entry(COM7, 8'h14);
      6'd3: entry = cfg_entry(COM15, 8'hD0);
      6'd4: entry = cfg_entry(RGB444, 8'h00);
      6'd5: entry = cfg_entry(CLKRC, 8'h01);
      6'd6: entry = cfg_entry(COM3, 8'h04);
      6'd7: entry = cfg_entry(COM14, 8'h1A);
`ifdef SCCB_TESTPAT_EN
      6'd8: entry = cfg_entry(8'h70, 8'hBA);
      6'd9: entry = cfg_entry(8'h71, 8'hB5);
`endif
      default: entry = CFG_END;
    endcase
  end

endmodule

// File: rtl/ov7670_sccb_config.sv
// SCCB write-only master that walks ov7670_cfg_rom and issues one 3-phase write per entry.
// Optional build macro: SCCB_TESTPAT_EN (adds colour-bar test pattern entries to the ROM).
module ov7670_sccb_config
  import ov7670_sccb_config_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 25000000,
  parameter int unsigned SCCB_FREQ_HZ = 100000,
  parameter logic [7:0]  DEV_ADDR     = 8'h42,
  parameter int unsigned DELAY_MS     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       sioc,
  output logic       siod_out,
  output logic       siod_oe,
  output logic       busy,
  output logic       done,
  output logic [5:0] reg_idx
);

  localparam int unsigned Q         = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int unsigned QW        = $clog2(Q + 1);
  localparam int unsigned DELAY_CYC = int'((64'(DELAY_MS) * 64'(CLK_FREQ_HZ)) / 64'd1000);
  localparam int unsigned DW        = $clog2(DELAY_CYC + 1);

  sccb_state_t   state, state_d;
  logic [QW-1:0] qcnt;
  logic [1:0]    qph, qph_d;
  logic [4:0]    bcnt, bcnt_d;
  logic [DW-1:0] dcnt, dcnt_d;
  logic [5:0]    idx_d;
  logic          busy_d, done_d;
  logic          tick, on_bus;
  logic [15:0]   entry;
  logic [27:0]   frame;
  logic          ack_bit;

  ov7670_cfg_rom u_rom (
    .idx   (reg_idx),
    .entry (entry)
  );

  // Leading 0 is the level left by the START condition, so bit 0 can hold it through q0.
  assign frame   = {1'b0, DEV_ADDR, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
  assign ack_bit = (bcnt == 5'd8) || (bcnt == 5'd17) || (bcnt == 5'd26);
  assign on_bus  = (state == START) || (state == BITS) || (state == STOP) || (state == GAP);
  assign tick    = (qcnt == QW'(Q - 1));

  always_ff @(posedge clk) begin
    if (rst || !on_bus || tick) qcnt <= '0;
    else                        qcnt <= qcnt + QW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      qph     <= '0;
      bcnt    <= '0;
      dcnt    <= '0;
      reg_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      qph     <= qph_d;
      bcnt    <= bcnt_d;
      dcnt    <= dcnt_d;
      reg_idx <= idx_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d  = state;
    qph_d    = qph;
    bcnt_d   = bcnt;
    dcnt_d   = dcnt;
    idx_d    = reg_idx;
    busy_d   = busy;
    done_d   = done;
    sioc     = 1'b1;
    siod_out = 1'b1;
    siod_oe  = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d = FETCH;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          idx_d   = '0;
        end
      end
      FETCH: begin
        qph_d  = '0;
        bcnt_d = '0;
        dcnt_d = '0;
        if (entry == CFG_END) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (entry == CFG_DELAY) begin
          state_d = WAIT;
        end else begin
          state_d = START;
        end
      end
      START: begin
        siod_oe  = 1'b1;
        siod_out = (qph == 2'd0);
        if (tick) begin
          qph_d = qph + 2'd1;
          if (qph == 2'd1) begin
            state_d = BITS;
            qph_d   = '0;
          end
        end
      end
      BITS: begin
        sioc     = qph[1];
        siod_oe  = !ack_bit;
        siod_out = (qph == 2'd0) ? frame[5'd27 - bcnt] : frame[5'd26 - bcnt];
        if (tick) begin
          qph_d = qph + 2'd1;
          if (qph == 2'd3) begin
            bcnt_d = bcnt + 5'd1;
            if (bcnt == 5'd26) begin
              state_d = STOP;
              bcnt_d  = '0;
            end
          end
        end
      end
      STOP: begin
        siod_oe  = 1'b1;
        sioc     = (qph != 2'd0);
        siod_out = (qph == 2'd2);
        if (tick) begin
          qph_d = qph + 2'd1;
          if (qph == 2'd2) begin
            state_d = GAP;
            qph_d   = '0;
          end
        end
      end
      GAP: begin
        siod_oe = 1'b1;
        if (tick) begin
          qph_d = qph + 2'd1;
          if (qph == 2'd3) begin
            idx_d   = reg_idx + 6'd1;
            state_d = (reg_idx == 6'd63) ? DONE : FETCH;
            busy_d  = (reg_idx != 6'd63);
            done_d  = (reg_idx == 6'd63);
          end
        end
      end
      WAIT: begin
        dcnt_d = dcnt + DW'(1);
        if (dcnt == DW'(DELAY_CYC - 1)) begin
          dcnt_d  = '0;
          idx_d   = reg_idx + 6'd1;
          state_d = (reg_idx == 6'd63) ? DONE : FETCH;
          busy_d  = (reg_idx != 6'd63);
          done_d  = (reg_idx == 6'd63);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Self-checking bench: an SCCB bus decoder checks every cycle against the expected write list.
// Clock is scaled to 248 kHz with SCCB at 1 kHz so Q stays 62 while the delay is 2480 cycles.
module tb_ov7670_sccb_config;

  localparam int BIT_CYC   = 248;   // 4 * Q
  localparam int START_CYC = 186;   // SIOD fall to first SIOC rise: 3 quarters
  localparam int IDX1_CYC  = 2481;  // one FETCH cycle + 2480-cycle delay
`ifdef SCCB_TESTPAT_EN
  localparam int N_EXP = 9;
`else
  localparam int N_EXP = 7;
`endif

  logic       clk = 1'b0;
  logic       rst, start;
  logic       sioc, siod_out, siod_oe, busy, done;
  logic [5:0] reg_idx;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_reg [9] = '{8'h12, 8'h12, 8'h40, 8'h8C, 8'h11, 8'h0C, 8'h3E, 8'h70, 8'h71};
  logic [7:0] exp_val [9] = '{8'h80, 8'h14, 8'hD0, 8'h00, 8'h01, 8'h04, 8'h1A, 8'hBA, 8'hB5};

  ov7670_sccb_config #(
    .CLK_FREQ_HZ (248000),
    .SCCB_FREQ_HZ(1000),
    .DEV_ADDR    (8'h42),
    .DELAY_MS    (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sioc    (sioc),
    .siod_out(siod_out),
    .siod_oe (siod_oe),
    .busy    (busy),
    .done    (done),
    .reg_idx (reg_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus decoder state
  logic        mon_en = 1'b0;
  logic        prev_scl = 1'b1, prev_sda = 1'b1, rst_prev = 1'b1;
  logic [5:0]  prev_idx = '0;
  logic        in_tx = 1'b0;
  int          bitcnt = 0;
  logic [26:0] shreg = '0;
  int          cyc = 0, t_last = 0;
  int          wr_cnt = 0;
  int          idx1_cnt = 0;
  logic        idx1_scl_low = 1'b0;
  logic        delay_checked = 1'b0;
  logic        line;

  always @(negedge clk) begin
    line = siod_oe ? siod_out : 1'b1;
    if (mon_en) begin
      if (rst_prev) begin
        in_tx = 1'b0;
        idx1_cnt = 0;
        idx1_scl_low = 1'b0;
      end else begin
        if (!busy) begin
          chk("idle_sioc", sioc, 1);
          chk("idle_siod", line, 1);
        end
        chk("busy_done_excl", busy & done, 0);
        if (prev_scl && sioc && prev_sda && !line) begin
          chk("no_repeated_start", in_tx, 0);
          in_tx = 1'b1;
          bitcnt = 0;
          shreg = '0;
          t_last = cyc;
        end else if (prev_scl && sioc && !prev_sda && line) begin
          chk("stop_in_tx", in_tx, 1);
          chk("stop_after_27_bits", bitcnt, 27);
          if (wr_cnt < N_EXP) begin
            chk("wr_dev_addr", shreg[26:19], 8'h42);
            chk("wr_reg", shreg[17:10], exp_reg[wr_cnt]);
            chk("wr_val", shreg[8:1], exp_val[wr_cnt]);
          end else begin
            chk("extra_write", wr_cnt, N_EXP);
          end
          wr_cnt++;
          in_tx = 1'b0;
        end else if (!prev_scl && sioc && in_tx && bitcnt < 27) begin
          if (bitcnt == 0) chk("start_to_bit0", cyc - t_last, START_CYC);
          else             chk("bit_period", cyc - t_last, BIT_CYC);
          chk("oe_on_bit", siod_oe, (bitcnt == 8 || bitcnt == 17 || bitcnt == 26) ? 0 : 1);
          shreg = {shreg[25:0], line};
          bitcnt++;
          t_last = cyc;
        end
        if (reg_idx == 6'd1) begin
          idx1_cnt++;
          if (!sioc) idx1_scl_low = 1'b1;
        end else if (prev_idx == 6'd1 && reg_idx == 6'd2) begin
          chk("delay_len", idx1_cnt, IDX1_CYC);
          chk("delay_no_sioc_edge", idx1_scl_low, 0);
          delay_checked = 1'b1;
          idx1_cnt = 0;
        end
      end
    end
    prev_scl = sioc;
    prev_sda = line;
    prev_idx = reg_idx;
    rst_prev = rst;
    cyc++;
  end

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_sioc"}, sioc, 1);
    chk({tag, "_siod_oe"}, siod_oe, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_reg_idx"}, reg_idx, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_reset_state("reset");
    end
    @(posedge clk); #2 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("start_during_reset_ignored", busy, 0);
    mon_en = 1'b1;

    // Abandon the first write at phase 2 bit 3 with a reset
    pulse_start();
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_reg_idx", reg_idx, 0);
    for (int i = 0; i < 10000 && !(in_tx && bitcnt == 12); i++) @(negedge clk);
    chk("reach_phase2_bit3", in_tx && bitcnt == 12, 1);
    repeat (134) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk_reset_state("midbyte_reset");

    // Clean run through the whole table
    pulse_start();
    for (int i = 0; i < 40000 && reg_idx != 6'd3; i++) @(negedge clk);
    chk("reach_third_write", reg_idx, 3);
    repeat (500) @(posedge clk);
    pulse_start();
    @(negedge clk);
    chk("busy_start_reg_idx_kept", reg_idx, 3);
    chk("busy_start_still_busy", busy, 1);

    for (int i = 0; i < 80000 && !done; i++) @(negedge clk);
    chk("done_reached", done, 1);
    chk("write_count", wr_cnt, N_EXP);
    chk("delay_window_seen", delay_checked, 1);
    chk("end_busy", busy, 0);
    chk("end_sioc", sioc, 1);
    chk("end_siod", siod_oe ? siod_out : 1'b1, 1);
    repeat (20) @(negedge clk);
    chk("done_held", done, 1);

    pulse_start();
    @(negedge clk);
    chk("restart_busy", busy, 1);
    chk("restart_done_clr", done, 0);
    chk("restart_reg_idx", reg_idx, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
